mult_seq: RTL and testbench
===========================

# mult_seq

Request sequencer that sits directly upstream of the 8x8 shift-and-add multiplier. It accepts operand pairs from the datapath over a valid/ready interface and buffers them in a small FIFO. It launches one multiplication at a time by driving the multiplier's a/b/start inputs and tracking its busy signal, then returns the 16-bit product with the request's tag over a valid/ready response interface. Products where either operand is zero bypass the multiplier.

## Interface
- DEPTH, 4, request FIFO entries; power of two, at least 2
- TAG_W, 4, width of the user tag carried alongside each request
- clk_in  input  1  clock
- rst_in  input  1  reset, asynchronous, active-high
- req_valid_in  input  1  request valid
- req_ready_out  output  1  FIFO can accept: high when not full
- req_a_in  input  8  operand a
- req_b_in  input  8  operand b
- req_tag_in  input  TAG_W  request tag
- mul_a_out  output  8  operand a to multiplier
- mul_b_out  output  8  operand b to multiplier
- mul_start_out  output  1  one-cycle start pulse to multiplier
- mul_busy_in  input  1  multiplier busy
- mul_y_in  input  16  multiplier product
- rsp_valid_out  output  1  response valid
- rsp_ready_in  input  1  response accepted
- rsp_y_out  output  16  product
- rsp_tag_out  output  TAG_W  tag of the request that produced rsp_y_out

## Operation
- FIFO push: on req_valid_in && req_ready_out. No write-through bypass: a pushed entry is visible at the head on the next cycle.
- Full FIFO: req_ready_out is low even if a pop happens in the same cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged.
- Pointers wrap modulo DEPTH. The occupancy counter is log2(DEPTH)+1 bits.
- FSM states: IDLE, START, WAIT_HI, WAIT_LO, RESP.
- IDLE, FIFO empty: stay in IDLE.
- IDLE, head has a==0 or b==0: pop the entry, set rsp_y_out=0 and rsp_tag_out=tag, go to RESP. The multiplier is not started.
- IDLE, head has both operands nonzero: pop the entry, register a/b into mul_a_out/mul_b_out and the tag into rsp_tag_out, go to START.
- START: mul_start_out=1 for exactly this cycle, then go to WAIT_HI.
- WAIT_HI: wait for mul_busy_in==1, then go to WAIT_LO. There is no timeout.
- WAIT_LO: on mul_busy_in==0, capture mul_y_in into rsp_y_out and go to RESP.
- RESP: rsp_valid_out=1. rsp_y_out and rsp_tag_out hold stable until rsp_ready_in. On acceptance, go to IDLE. There is one bubble cycle before the next pop.
- mul_a_out and mul_b_out hold their values from the pop until the next launch.
- Only one request is in flight, so responses leave in request order.
- Reset values: rsp_valid_out=0, rsp_y_out=0, rsp_tag_out=0, mul_a_out=0, mul_b_out=0, mul_start_out=0, req_ready_out=1 (FIFO empty), FSM in IDLE.
- Reset mid-operation: the FIFO is emptied and any in-flight result is discarded. The multiplier shares rst_in, so no cleanup is needed.

## Timing
- mul_start_out, rsp_valid_out and req_ready_out are decoded directly from registered state and the occupancy counter, with no combinational path from the other inputs.
- Request accepted at edge 0 into an empty FIFO, with the FSM idle:
  - IDLE pops during cycle 1.
  - START is cycle 2.
  - The multiplier samples start at edge 3 and is busy for 10 cycles (cycles 3-12).
  - WAIT_LO sees busy low in cycle 13.
  - rsp_valid_out is high from cycle 14.
  - Total latency is 14 cycles when rsp_ready_in is held high.
- Zero-operand shortcut: rsp_valid_out is high in cycle 2.
- Back-to-back throughput with rsp_ready_in held high: one result per 14 cycles. Each result is accepted in its first RESP cycle, then there is one IDLE cycle with pop.
- rsp_ready_in low: the FSM stalls in RESP. The FIFO keeps accepting requests until it is full.

## Test plan
- Single request a=0x0D, b=0x0B, tag=3, rsp_ready_in=1 -> mul_start_out pulses once in cycle 2; rsp_valid_out rises in cycle 14 with rsp_y_out=0x008F, tag=3.
- Max operands a=0xFF, b=0xFF -> rsp_y_out=0xFE01. Zero operands a=0x00, b=0x7F -> rsp_y_out=0 in cycle 2, and mul_start_out never asserts.
- Push 5 requests back-to-back with DEPTH=4 and rsp_ready_in=0 -> req_ready_out drops after the 5th push (4 in the FIFO plus 1 in flight). The 6th is refused until the first response is accepted.
- Stream of 8 random requests (tags 0..7) with random rsp_ready_in -> products match a*b, tags come out in order, and rsp_y_out/rsp_tag_out are stable while valid && !ready.
- Assert rst_in in cycle 6 of an active multiply with 2 entries queued -> all outputs return to reset values, no response is issued, and a new request afterwards completes with correct latency.
- Push and pop in the same cycle with 2 entries in the FIFO -> occupancy stays at 2, and the order is preserved across pointer wrap after more than DEPTH total pushes.

Source files
------------

// File: rtl/mult_seq_if.sv
// Request/response bundle between the datapath and the multiplier sequencer.
// The datapath is the master: it offers operand pairs and consumes products.
interface mult_seq_if #(
  parameter int TAG_W = 4
);
  logic             req_valid_in;
  logic             req_ready_out;
  logic [7:0]       req_a_in;
  logic [7:0]       req_b_in;
  logic [TAG_W-1:0] req_tag_in;
  logic             rsp_valid_out;
  logic             rsp_ready_in;
  logic [15:0]      rsp_y_out;
  logic [TAG_W-1:0] rsp_tag_out;

  modport master (
    output req_valid_in, req_a_in, req_b_in, req_tag_in, rsp_ready_in,
    input  req_ready_out, rsp_valid_out, rsp_y_out, rsp_tag_out
  );

  modport slave (
    input  req_valid_in, req_a_in, req_b_in, req_tag_in, rsp_ready_in,
    output req_ready_out, rsp_valid_out, rsp_y_out, rsp_tag_out
  );
endinterface

// File: rtl/mult_seq.sv
// Buffers operand pairs in a small FIFO and runs them one at a time through an
// external shift-and-add multiplier; zero operands skip the multiplier entirely.
module mult_seq #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  mult_seq_if.slave   bus,
  output logic [7:0]  mul_a_out,
  output logic [7:0]  mul_b_out,
  output logic        mul_start_out,
  input  logic        mul_busy_in,
  input  logic [15:0] mul_y_in
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 16 + TAG_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [7:0]       r_mul_a;
  logic [7:0]       r_mul_b;
  logic [15:0]      r_rsp_y;
  logic [TAG_W-1:0] r_rsp_tag;

  logic             w_push;
  logic             w_pop;
  logic             w_zero;
  logic             w_ready;
  logic             w_start;
  logic             w_rsp_valid;
  logic [7:0]       w_head_a;
  logic [7:0]       w_head_b;
  logic [TAG_W-1:0] w_head_tag;

  // Ready depends only on occupancy, so a same-cycle pop never unblocks a full FIFO.
  assign w_ready = (r_count != FULL_CNT);
  assign w_push  = bus.req_valid_in && w_ready;
  assign w_pop   = (r_state == IDLE) && (r_count != '0);
  assign {w_head_a, w_head_b, w_head_tag} = r_mem[r_rd_ptr];
  assign w_zero  = (w_head_a == 8'd0) || (w_head_b == 8'd0);

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.req_a_in, bus.req_b_in, bus.req_tag_in};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      IDLE:    if (r_count != '0) w_next = w_zero ? RESP : START;
      START: begin
        w_start = 1'b1;
        w_next  = WAIT_HI;
      end
      WAIT_HI: if (mul_busy_in) w_next = WAIT_LO;
      WAIT_LO: if (!mul_busy_in) w_next = RESP;
      RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready_in) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operands stay on the multiplier until the next launch; result held through RESP.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_rsp_y   <= '0;
      r_rsp_tag <= '0;
    end else begin
      if (w_pop) begin
        r_rsp_tag <= w_head_tag;
        if (w_zero) begin
          r_rsp_y <= '0;
        end else begin
          r_mul_a <= w_head_a;
          r_mul_b <= w_head_b;
        end
      end
      if ((r_state == WAIT_LO) && !mul_busy_in) r_rsp_y <= mul_y_in;
    end
  end

  assign bus.req_ready_out = w_ready;
  assign bus.rsp_valid_out = w_rsp_valid;
  assign bus.rsp_y_out     = r_rsp_y;
  assign bus.rsp_tag_out   = r_rsp_tag;
  assign mul_a_out         = r_mul_a;
  assign mul_b_out         = r_mul_b;
  assign mul_start_out     = w_start;
endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: a behavioural 10-cycle multiplier model plus directed scenarios
// with hand-computed products, tags, latencies and flow-control expectations.
`timescale 1ns/1ps
module tb_mult_seq;
  localparam int TAG_W = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [7:0]  mul_a_out;
  logic [7:0]  mul_b_out;
  logic        mul_start_out;
  logic        mul_busy_in;
  logic [15:0] mul_y_in;

  int total = 0;
  int bad   = 0;
  int starts = 0;

  mult_seq_if #(.TAG_W(TAG_W)) bus ();

  mult_seq #(.DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .bus           (bus),
    .mul_a_out     (mul_a_out),
    .mul_b_out     (mul_b_out),
    .mul_start_out (mul_start_out),
    .mul_busy_in   (mul_busy_in),
    .mul_y_in      (mul_y_in)
  );

  always #5 clk_in = ~clk_in;

  // Multiplier model: start sampled at an edge, busy for 10 cycles, product valid when busy falls.
  logic        m_busy;
  logic [3:0]  m_cnt;
  logic [15:0] m_y;
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      m_busy <= 1'b0;
      m_cnt  <= 4'd0;
      m_y    <= 16'h0000;
    end else if (mul_start_out) begin
      m_busy <= 1'b1;
      m_cnt  <= 4'd9;
      m_y    <= 16'hDEAD;
    end else if (m_busy) begin
      if (m_cnt == 4'd0) begin
        m_busy <= 1'b0;
        m_y    <= mul_a_out * mul_b_out;
      end else begin
        m_cnt <= m_cnt - 4'd1;
      end
    end
  end
  assign mul_busy_in = m_busy;
  assign mul_y_in    = m_y;

  always @(posedge clk_in) if (mul_start_out) starts <= starts + 1;

  logic [7:0]  sa [8] = '{8'h12, 8'hFF, 8'h00, 8'h80, 8'hA5, 8'h07, 8'h10, 8'hC3};
  logic [7:0]  sb [8] = '{8'h34, 8'h01, 8'h55, 8'h80, 8'h5A, 8'h00, 8'h10, 8'h3C};
  logic [15:0] sy [8] = '{16'h03A8, 16'h00FF, 16'h0000, 16'h4000,
                          16'h3A02, 16'h0000, 16'h0100, 16'h2DB4};

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    tick();
    tick();
    total++; if (bus.rsp_valid_out !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid_out); end
    total++; if (bus.rsp_y_out !== 16'h0000) begin bad++; $display("FAIL reset_rsp_y: got %h want 0000", bus.rsp_y_out); end
    total++; if (bus.rsp_tag_out !== 4'h0) begin bad++; $display("FAIL reset_rsp_tag: got %h want 0", bus.rsp_tag_out); end
    total++; if (mul_a_out !== 8'h00) begin bad++; $display("FAIL reset_mul_a: got %h want 00", mul_a_out); end
    total++; if (mul_b_out !== 8'h00) begin bad++; $display("FAIL reset_mul_b: got %h want 00", mul_b_out); end
    total++; if (mul_start_out !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", mul_start_out); end
    total++; if (bus.req_ready_out !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready_out); end
    rst_in = 1'b0;
    tick();
    total++; if (bus.rsp_valid_out !== 1'b0) begin bad++; $display("FAIL post_reset_valid: got %b want 0", bus.rsp_valid_out); end
  endtask

  task automatic test_single(input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag,
                             input logic [15:0] exp_y);
    int n, sn, s0;
    bus.rsp_ready_in = 1'b1;
    s0 = starts;
    total++; if (bus.req_ready_out !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", bus.req_ready_out); end
    bus.req_valid_in = 1'b1; bus.req_a_in = a; bus.req_b_in = b; bus.req_tag_in = tag;
    tick();
    bus.req_valid_in = 1'b0;
    n = 0; sn = -1;
    while (!bus.rsp_valid_out && n < 40) begin
      if (mul_start_out && sn < 0) sn = n;
      tick();
      n++;
    end
    total++; if (n != 13) begin bad++; $display("FAIL single_latency: got %0d edges want 13", n); end
    total++; if (sn != 1) begin bad++; $display("FAIL single_start_cycle: got %0d want 1", sn); end
    total++; if (bus.rsp_y_out !== exp_y || bus.rsp_tag_out !== tag) begin
      bad++; $display("FAIL single_result: got y=%h tag=%h want y=%h tag=%h", bus.rsp_y_out, bus.rsp_tag_out, exp_y, tag);
    end
    tick();
    total++; if (starts - s0 != 1) begin bad++; $display("FAIL single_start_count: got %0d want 1", starts - s0); end
    total++; if (bus.rsp_valid_out !== 1'b0) begin bad++; $display("FAIL single_valid_drop: got %b want 0", bus.rsp_valid_out); end
  endtask

  task automatic test_zero();
    logic [7:0] za [2] = '{8'h00, 8'h55};
    logic [7:0] zb [2] = '{8'h7F, 8'h00};
    logic [3:0] zt [2] = '{4'h6, 4'h9};
    int n, s0;
    bus.rsp_ready_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s0 = starts;
      bus.req_valid_in = 1'b1; bus.req_a_in = za[i]; bus.req_b_in = zb[i]; bus.req_tag_in = zt[i];
      tick();
      bus.req_valid_in = 1'b0;
      n = 0;
      while (!bus.rsp_valid_out && n < 40) begin tick(); n++; end
      total++; if (n != 1) begin bad++; $display("FAIL zero_latency%0d: got %0d edges want 1", i, n); end
      total++; if (bus.rsp_y_out !== 16'h0000 || bus.rsp_tag_out !== zt[i]) begin
        bad++; $display("FAIL zero_result%0d: got y=%h tag=%h want y=0000 tag=%h", i, bus.rsp_y_out, bus.rsp_tag_out, zt[i]);
      end
      tick();
      tick();
      total++; if (starts != s0) begin bad++; $display("FAIL zero_no_start%0d: got %0d starts want 0", i, starts - s0); end
    end
  endtask

  task automatic test_back_to_back();
    int n, t1, t2;
    bus.rsp_ready_in = 1'b1;
    bus.req_valid_in = 1'b1; bus.req_a_in = 8'h03; bus.req_b_in = 8'h05; bus.req_tag_in = 4'h1;
    tick();
    bus.req_a_in = 8'h09; bus.req_b_in = 8'h09; bus.req_tag_in = 4'h2;
    tick();
    bus.req_valid_in = 1'b0;
    t1 = -1; t2 = -1;
    for (n = 1; n < 60 && t2 < 0; n++) begin
      if (bus.rsp_valid_out) begin
        if (t1 < 0) begin
          t1 = n;
          total++; if (bus.rsp_y_out !== 16'h000F || bus.rsp_tag_out !== 4'h1) begin
            bad++; $display("FAIL b2b_first: got y=%h tag=%h want y=000f tag=1", bus.rsp_y_out, bus.rsp_tag_out);
          end
        end else begin
          t2 = n;
          total++; if (bus.rsp_y_out !== 16'h0051 || bus.rsp_tag_out !== 4'h2) begin
            bad++; $display("FAIL b2b_second: got y=%h tag=%h want y=0051 tag=2", bus.rsp_y_out, bus.rsp_tag_out);
          end
        end
      end
      tick();
    end
    total++; if (t1 != 13) begin bad++; $display("FAIL b2b_first_time: got %0d want 13", t1); end
    total++; if (t2 - t1 != 14) begin bad++; $display("FAIL b2b_spacing: got %0d want 14", t2 - t1); end
  endtask

  task automatic test_full();
    logic [15:0] ey [5] = '{16'h000C, 16'h0014, 16'h001E, 16'h002A, 16'h003F};
    int n, bad_rdy, unstable;
    bus.rsp_ready_in = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      total++; if (bus.req_ready_out !== 1'b1) begin bad++; $display("FAIL full_ready_push%0d: got %b want 1", k, bus.req_ready_out); end
      bus.req_valid_in = 1'b1; bus.req_a_in = 8'(k + 1); bus.req_b_in = 8'(k + 2); bus.req_tag_in = 4'(k);
      tick();
    end
    bus.req_a_in = 8'h07; bus.req_b_in = 8'h09; bus.req_tag_in = 4'h6;
    total++; if (bus.req_ready_out !== 1'b0) begin bad++; $display("FAIL full_ready_after5: got %b want 0", bus.req_ready_out); end
    n = 0; bad_rdy = 0;
    while (!bus.rsp_valid_out && n < 40) begin
      if (bus.req_ready_out) bad_rdy++;
      tick(); n++;
    end
    total++; if (bus.rsp_y_out !== 16'h0006 || bus.rsp_tag_out !== 4'h1 || n >= 40) begin
      bad++; $display("FAIL full_first_rsp: got y=%h tag=%h want y=0006 tag=1", bus.rsp_y_out, bus.rsp_tag_out);
    end
    unstable = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.req_ready_out) bad_rdy++;
      if (!bus.rsp_valid_out || bus.rsp_y_out !== 16'h0006 || bus.rsp_tag_out !== 4'h1) unstable++;
    end
    total++; if (bad_rdy != 0) begin bad++; $display("FAIL full_ready_held_low: got %0d ready cycles want 0", bad_rdy); end
    total++; if (unstable != 0) begin bad++; $display("FAIL full_stall_stable: got %0d unstable cycles want 0", unstable); end
    bus.rsp_ready_in = 1'b1;
    tick();
    total++; if (bus.req_ready_out !== 1'b0) begin bad++; $display("FAIL full_ready_during_pop: got %b want 0", bus.req_ready_out); end
    tick();
    total++; if (bus.req_ready_out !== 1'b1) begin bad++; $display("FAIL full_ready_after_pop: got %b want 1", bus.req_ready_out); end
    tick();
    bus.req_valid_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!bus.rsp_valid_out && n < 40) begin tick(); n++; end
      total++; if (n >= 40 || bus.rsp_y_out !== ey[i] || bus.rsp_tag_out !== 4'(i + 2)) begin
        bad++; $display("FAIL full_drain%0d: got y=%h tag=%h want y=%h tag=%h", i, bus.rsp_y_out, bus.rsp_tag_out, ey[i], 4'(i + 2));
      end
      tick();
    end
  endtask

  task automatic test_stream();
    fork
      begin : prod
        int j = 0;
        int cyc = 0;
        while (j < 8 && cyc < 3000) begin
          bus.req_valid_in = 1'b1; bus.req_a_in = sa[j]; bus.req_b_in = sb[j]; bus.req_tag_in = 4'(j);
          if (bus.req_ready_out) j++;
          tick(); cyc++;
        end
        bus.req_valid_in = 1'b0;
      end
      begin : cons
        int i = 0;
        int cyc = 0;
        logic held = 1'b0;
        logic [15:0] hy = '0;
        logic [3:0]  ht = '0;
        while (i < 8 && cyc < 3000) begin
          bus.rsp_ready_in = 1'($urandom_range(0, 1));
          if (held) begin
            total++; if (!bus.rsp_valid_out || bus.rsp_y_out !== hy || bus.rsp_tag_out !== ht) begin
              bad++; $display("FAIL stream_stable: got v=%b y=%h tag=%h want v=1 y=%h tag=%h", bus.rsp_valid_out, bus.rsp_y_out, bus.rsp_tag_out, hy, ht);
            end
          end
          if (bus.rsp_valid_out) begin
            if (bus.rsp_ready_in) begin
              total++; if (bus.rsp_y_out !== sy[i] || bus.rsp_tag_out !== 4'(i)) begin
                bad++; $display("FAIL stream_rsp%0d: got y=%h tag=%h want y=%h tag=%h", i, bus.rsp_y_out, bus.rsp_tag_out, sy[i], 4'(i));
              end
              i++; held = 1'b0;
            end else begin
              held = 1'b1; hy = bus.rsp_y_out; ht = bus.rsp_tag_out;
            end
          end
          tick(); cyc++;
        end
        total++; if (i != 8) begin bad++; $display("FAIL stream_count: got %0d want 8", i); end
      end
    join
  endtask

  task automatic test_reset_mid();
    int s1, seen;
    bus.rsp_ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.req_valid_in = 1'b1; bus.req_a_in = 8'h21; bus.req_b_in = 8'h03; bus.req_tag_in = 4'(k + 1);
      tick();
    end
    bus.req_valid_in = 1'b0;
    tick(); tick(); tick();
    rst_in = 1'b1;
    #1;
    total++; if (bus.rsp_valid_out !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", bus.rsp_valid_out); end
    total++; if (bus.rsp_y_out !== 16'h0000) begin bad++; $display("FAIL midrst_y: got %h want 0000", bus.rsp_y_out); end
    total++; if (bus.rsp_tag_out !== 4'h0) begin bad++; $display("FAIL midrst_tag: got %h want 0", bus.rsp_tag_out); end
    total++; if (mul_a_out !== 8'h00 || mul_b_out !== 8'h00) begin bad++; $display("FAIL midrst_mul_ab: got %h/%h want 00/00", mul_a_out, mul_b_out); end
    total++; if (mul_start_out !== 1'b0) begin bad++; $display("FAIL midrst_start: got %b want 0", mul_start_out); end
    total++; if (bus.req_ready_out !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", bus.req_ready_out); end
    tick();
    rst_in = 1'b0;
    s1 = starts; seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.rsp_valid_out) seen++;
      tick();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midrst_no_rsp: got %0d valid cycles want 0", seen); end
    total++; if (starts != s1) begin bad++; $display("FAIL midrst_no_launch: got %0d starts want 0", starts - s1); end
    test_single(8'h0D, 8'h0B, 4'h5, 16'h008F);
  endtask

  task automatic test_wrap();
    logic [15:0] ey [5] = '{16'h0039, 16'h0102, 16'h00E1, 16'h0100, 16'h0000};
    logic [3:0]  et [5] = '{4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    int n;
    bus.rsp_ready_in = 1'b1;
    bus.req_valid_in = 1'b1; bus.req_a_in = 8'h11; bus.req_b_in = 8'h02; bus.req_tag_in = 4'hA;
    tick();
    bus.req_a_in = 8'h13; bus.req_b_in = 8'h03; bus.req_tag_in = 4'hB;
    tick();
    bus.req_a_in = 8'h02; bus.req_b_in = 8'h81; bus.req_tag_in = 4'hC;
    tick();
    bus.req_valid_in = 1'b0;
    n = 0;
    while (!bus.rsp_valid_out && n < 40) begin tick(); n++; end
    total++; if (n >= 40 || bus.rsp_y_out !== 16'h0022 || bus.rsp_tag_out !== 4'hA) begin
      bad++; $display("FAIL wrap_first: got y=%h tag=%h want y=0022 tag=a", bus.rsp_y_out, bus.rsp_tag_out);
    end
    tick();
    total++; if (dut.r_count !== 3'd2) begin bad++; $display("FAIL wrap_occ_before: got %0d want 2", dut.r_count); end
    bus.req_valid_in = 1'b1; bus.req_a_in = 8'h0F; bus.req_b_in = 8'h0F; bus.req_tag_in = 4'hD;
    tick();
    total++; if (dut.r_count !== 3'd2) begin bad++; $display("FAIL wrap_occ_pushpop: got %0d want 2", dut.r_count); end
    bus.req_a_in = 8'h40; bus.req_b_in = 8'h04; bus.req_tag_in = 4'hE;
    tick();
    bus.req_a_in = 8'h00; bus.req_b_in = 8'h33; bus.req_tag_in = 4'hF;
    tick();
    bus.req_valid_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!bus.rsp_valid_out && n < 40) begin tick(); n++; end
      total++; if (n >= 40 || bus.rsp_y_out !== ey[i] || bus.rsp_tag_out !== et[i]) begin
        bad++; $display("FAIL wrap_drain%0d: got y=%h tag=%h want y=%h tag=%h", i, bus.rsp_y_out, bus.rsp_tag_out, ey[i], et[i]);
      end
      tick();
    end
  endtask

  initial begin
    bus.req_valid_in = 1'b0;
    bus.req_a_in     = 8'h00;
    bus.req_b_in     = 8'h00;
    bus.req_tag_in   = 4'h0;
    bus.rsp_ready_in = 1'b1;
    #2;
    test_reset();
    test_single(8'h0D, 8'h0B, 4'h3, 16'h008F);
    test_single(8'hFF, 8'hFF, 4'h4, 16'hFE01);
    test_zero();
    test_back_to_back();
    test_full();
    test_stream();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
